// File: rtl/gpio_input_filter.sv
// gpio_input_filter: per-pin pad synchroniser, programmable debounce and rise/fall event pulses
module gpio_input_filter #(
    parameter int WIDTH       = 15,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 io_clock,
    input  logic                 io_reset_n,
    input  logic [WIDTH-1:0]     io_pins_raw,
    input  logic [CNT_WIDTH-1:0] io_debounceLimit,
    input  logic [WIDTH-1:0]     io_bypass,
    output logic [WIDTH-1:0]     io_pins_read,
    output logic [WIDTH-1:0]     io_rise,
    output logic [WIDTH-1:0]     io_fall
);
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  sync, stable, stable_nx;
    logic [WIDTH-1:0][CNT_WIDTH-1:0]   cnt, cnt_nx;
    logic [WIDTH-1:0][CNT_WIDTH:0]     cnt_inc;
    logic [CNT_WIDTH:0]                lim;

    assign sync         = sync_q[SYNC_STAGES-1];
    assign io_pins_read = stable;

    // Next stable level and count per pin; the extra count bit keeps cnt+1 from wrapping in the compare
    always_comb begin
        lim = (io_debounceLimit == '0) ? (CNT_WIDTH+1)'(1) : {1'b0, io_debounceLimit};
        for (int i = 0; i < WIDTH; i++) begin
            cnt_inc[i]   = {1'b0, cnt[i]} + (CNT_WIDTH+1)'(1);
            stable_nx[i] = (io_bypass[i] || cnt_inc[i] >= lim) ? sync[i] : stable[i];
            cnt_nx[i]    = (io_bypass[i] || sync[i] == stable[i] || cnt_inc[i] >= lim) ? '0 : cnt_inc[i][CNT_WIDTH-1:0];
        end
    end

    // Plain flop chain bringing each asynchronous pad level into the clock domain
    always_ff @(posedge io_clock or negedge io_reset_n) begin
        if (!io_reset_n)
            sync_q <= '0;
        else
            sync_q <= {sync_q[SYNC_STAGES-2:0], io_pins_raw};
    end

    // Debounce state plus event pulses registered alongside the stable level
    always_ff @(posedge io_clock or negedge io_reset_n) begin
        if (!io_reset_n) begin
            stable  <= '0;
            cnt     <= '0;
            io_rise <= '0;
            io_fall <= '0;
        end else begin
            stable  <= stable_nx;
            cnt     <= cnt_nx;
            io_rise <= stable_nx & ~stable;
            io_fall <= ~stable_nx & stable;
        end
    end
endmodule

// File: doc/gpio_input_filter.md
# gpio_input_filter

Per-pin input conditioner between the GPIO pad input buffers and the SoC `pins_read` inputs. It synchronises each asynchronous pad level into the system clock domain and debounces it with a programmable stability window. It also produces single-cycle rise/fall event pulses for interrupt logic. One instance per GPIO bank (status bank, bank 1); the I2C read lines may use a `WIDTH=2` instance for glitch suppression.

## Interface
Parameters:
- `WIDTH`, 15: number of pins in the bank.
- `SYNC_STAGES`, 2: synchroniser flops per pin; legal range 2..4.
- `CNT_WIDTH`, 16: width of the per-pin debounce counter and of `io_debounceLimit`.

Ports:
- `io_clock`, input, 1: system clock. Single clock domain; every flop is on it.
- `io_reset_n`, input, 1: reset, asynchronous assert, active-low. Release is synchronised externally.
- `io_pins_raw`, input, `WIDTH`: pad levels from the input buffers; asynchronous.
- `io_debounceLimit`, input, `CNT_WIDTH`: number of consecutive cycles of changed level required before accepting it. Quasi-static.
- `io_bypass`, input, `WIDTH`: per pin, 1 = no debounce (synchroniser only).
- `io_pins_read`, output, `WIDTH`: debounced level, to SoC `pins_read`.
- `io_rise`, output, `WIDTH`: 1-cycle pulse when `io_pins_read[i]` goes 0→1.
- `io_fall`, output, `WIDTH`: 1-cycle pulse when `io_pins_read[i]` goes 1→0.

## Operation
- Per pin `i`, all pins independent and identical:
  - Synchroniser: a chain of `SYNC_STAGES` flops. Its last stage is `sync[i]`. No logic between stages.
  - Stable register: `stable[i]` drives `io_pins_read[i]`.
  - Counter: `cnt[i]`, `CNT_WIDTH` bits.
- Effective limit `L = max(io_debounceLimit, 1)`. A limit of 0 behaves exactly as 1.
- Debounce rule, evaluated on every clock edge with `io_bypass[i]=0`:
  - `sync[i] == stable[i]`: set `cnt[i] <= 0`.
  - `sync[i] != stable[i]` and `cnt[i] + 1 >= L`: set `stable[i] <= sync[i]` and `cnt[i] <= 0`.
  - `sync[i] != stable[i]` otherwise: set `cnt[i] <= cnt[i] + 1`.
- The counter never exceeds `L-1`, so it never wraps. The compare is `>=`: if the limit is lowered mid-count below the current count, the pin accepts on the next mismatching edge.
- A glitch shorter than `L` cycles (after synchronisation) has no effect. Any return to the stable level clears the count.
- Bypass (`io_bypass[i]=1`):
  - `stable[i] <= sync[i]` every edge.
  - `cnt[i]` held at 0.
  - Toggling bypass mid-count discards the partial count.
- Edge outputs:
  - `io_rise[i]` is registered and is high for exactly the cycle in which `stable[i]` first shows 1 after being 0.
  - `io_fall[i]` is the mirror case.
  - Rise and fall are never high together on one pin.
  - Outputs are registered in parallel with `stable`, not derived from it one cycle later.
- Reset (asynchronous, `io_reset_n=0`): all synchroniser flops, `stable`, `cnt`, `io_rise` and `io_fall` go to 0, so `io_pins_read=0`. Reset mid-count aborts the count. The first edge after release produces no rise pulse for pins that are low, and no spurious pulses at all.
- Pads held high through reset release `io_pins_read` to 1 after the normal latency below, with one `io_rise` pulse. This is intentional; software clears the pending event.

## Timing
- Counting edges from the first `io_clock` edge that captures a new raw level:
  - `sync` changes after edge `SYNC_STAGES`.
  - With bypass or `L=1`, `io_pins_read` and the pulse change after edge `SYNC_STAGES+1`.
  - General case: `io_pins_read` changes after edge `SYNC_STAGES + L`.
- The pulse width is exactly 1 cycle. Back-to-back accepted changes on one pin are at least `L` cycles apart.
- A change of `io_debounceLimit` takes effect on the next edge. No handshake is involved.
- There are no combinational paths from any input to any output.

## Test plan
- Reset with `io_pins_raw=all 1`, `L=4`, `SYNC_STAGES=2`, release → all outputs 0 during reset. `io_pins_read` goes to all 1 after edge 6, with a single `io_rise=all 1` pulse on that same cycle.
- Pin 0 low, `L=10`, raise `io_pins_raw[0]` → `io_pins_read[0]` goes 1 after edge 12. `io_rise[0]` is high exactly one cycle. Other pins do not change.
- Pin 3, `L=10`, send a 9-cycle high pulse, then low → no change and no pulse. A 10-cycle high pulse → accepted; `io_fall[3]` follows 10 cycles after the return to low.
- `io_debounceLimit=0` and `io_bypass[5]=1` on a separate pin: toggle `io_pins_raw[5]` every 2 cycles → `io_pins_read[5]` follows with 3-cycle latency. Each transition pulses `io_rise` or `io_fall`.
- Mid-count (cnt=6 of `L=100`), assert `io_reset_n=0` for 1 cycle → outputs 0 immediately. After release, a full 100-cycle window is required again.
- Lower `io_debounceLimit` from 100 to 5 while pin 7 has cnt=20 mismatching → `io_pins_read[7]` updates on the next edge.
